img_ram_arbiter: RTL and testbench



---
 rtl/img_ram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_img_ram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_ram_arbiter.sv
// img_ram_arbiter
//
// Shares one single-port image RAM between the VGA pixel fetch path and the
// CPU/MMIO image-write path. VGA reads win over writes. A write waits for an
// idle cycle, but it is forced through after STARVE_LIMIT consecutive denied
// cycles. In that case the competing read is dropped and flagged by rd_miss.
//
// Optional feature: define IMG_FILL_EN to add a fill engine. The engine writes
// fill_value to every word 0..DEPTH-1, one word per cycle.
//
// Ports
//   clk, reset              system clock; synchronous active-high reset
//   rd_req, rd_addr         VGA read request, one address per cycle
//   rd_data                 read data, passed straight through from ram_dataOut
//   rd_valid                rd_data holds the read granted in the previous cycle
//   rd_miss                 the previous cycle's read request was dropped
//   wr_req, wr_addr, wr_data  write request; held stable until wr_ack
//   wr_ack                  one-cycle pulse; the write commits at this edge
//   ram_wEn, ram_addr, ram_dataIn, ram_dataOut   RAM-side connections
//   fill_start, fill_value, fill_busy, fill_done (IMG_FILL_EN only)

module img_ram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DEPTH         = 256,
    parameter int STARVE_LIMIT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     rd_miss,
    input  logic                     wr_req,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ack,
`ifdef IMG_FILL_EN
    input  logic                     fill_start,
    input  logic [DATA_WIDTH-1:0]    fill_value,
    output logic                     fill_busy,
    output logic                     fill_done,
`endif
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    // A zero limit disables forcing. The counter keeps one bit so that it
    // still has a legal width in that case.
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    if (DEPTH < 1 || DEPTH > (1 << ADDRESS_WIDTH)) begin : g_depth_check
        $error("img_ram_arbiter: DEPTH does not fit in ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

    grant_t              grant;
    logic [STARVE_W-1:0] starve_cnt;
    logic                force_write;
    logic                fill_active;

    // The RAM holds dataOut during write cycles. rd_data therefore needs no
    // register of its own; rd_valid tells the reader whether the data is fresh.
    assign rd_data = ram_dataOut;

    // wr_req is part of the condition because the counter is registered.
    // A writer that drops in the cycle the counter saturates must not be forced.
    assign force_write = (STARVE_LIMIT > 0) && wr_req &&
                         (starve_cnt == STARVE_W'(STARVE_LIMIT));

`ifdef IMG_FILL_EN
    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_RUN,
        FILL_DONE
    } fill_state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    fill_state_t              fill_state;
    fill_state_t              fill_state_next;
    logic [ADDRESS_WIDTH-1:0] fill_ptr;
    logic [DATA_WIDTH-1:0]    fill_val;
    logic                     fill_advance;

    assign fill_busy   = (fill_state == FILL_RUN);
    assign fill_done   = (fill_state == FILL_DONE);
    assign fill_active = fill_busy;

    // Fill state, pointer and latched value. The pointer moves only when the
    // fill actually got the RAM, so a forced external write stalls it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_state <= FILL_IDLE;
            fill_ptr   <= '0;
            fill_val   <= '0;
        end else begin
            fill_state <= fill_state_next;
            if (fill_state == FILL_IDLE && fill_start) begin
                fill_ptr <= '0;
                fill_val <= fill_value;
            end else if (fill_advance) begin
                fill_ptr <= fill_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        fill_state_next = fill_state;
        case (fill_state)
            FILL_IDLE: if (fill_start) fill_state_next = FILL_RUN;
            FILL_RUN:  if (fill_advance && fill_ptr == LAST_ADDR) fill_state_next = FILL_DONE;
            FILL_DONE: fill_state_next = FILL_IDLE;
            default:   fill_state_next = FILL_IDLE;
        endcase
    end
`else
    assign fill_active = 1'b0;
`endif

    // Single grant per cycle, in priority order: forced write, fill, read, write.
    always_comb begin
        grant      = GRANT_NONE;
        wr_ack     = 1'b0;
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
`ifdef IMG_FILL_EN
        fill_advance = 1'b0;
`endif
        if (force_write) begin
            grant      = GRANT_WRITE;
            wr_ack     = 1'b1;
            ram_wEn    = 1'b1;
            ram_addr   = wr_addr;
            ram_dataIn = wr_data;
`ifdef IMG_FILL_EN
        end else if (fill_busy) begin
            grant        = GRANT_WRITE;
            ram_wEn      = 1'b1;
            ram_addr     = fill_ptr;
            ram_dataIn   = fill_val;
            fill_advance = 1'b1;
`endif
        end else if (rd_req) begin
            grant    = GRANT_READ;
            ram_addr = rd_addr;
        end else if (wr_req) begin
            grant      = GRANT_WRITE;
            wr_ack     = 1'b1;
            ram_wEn    = 1'b1;
            ram_addr   = wr_addr;
            ram_dataIn = wr_data;
        end
    end

    // The counter only measures one continuous wait. An abandoned request,
    // a completed write, or a running fill starts the count over.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!wr_req || wr_ack || fill_active) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read status follows the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
        end else begin
            rd_valid <= (grant == GRANT_READ);
            rd_miss  <= rd_req && (grant != GRANT_READ);
        end
    end

endmodule

// File: tb/tb_img_ram_arbiter.sv
// tb_img_ram_arbiter
//
// Bench for img_ram_arbiter with default parameters (STARVE_LIMIT = 16).
// A behavioural single-port RAM with a registered read sits on the RAM
// ports. The expected image contents are tracked in model_mem.
// Define IMG_FILL_EN to include the fill-engine scenarios.

module tb_img_ram_arbiter;

    localparam int LIMIT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_miss;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       ram_wEn;
    logic [7:0] ram_addr;
    logic [7:0] ram_dataIn;
    logic [7:0] ram_q;
`ifdef IMG_FILL_EN
    logic       fill_start;
    logic [7:0] fill_value;
    logic       fill_busy;
    logic       fill_done;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [0:255];
    logic [7:0] ram_mem   [0:255];
    logic       ram_loaded = 1'b0;

    always #5 clk = ~clk;

    img_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_miss     (rd_miss),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
`ifdef IMG_FILL_EN
        .fill_start  (fill_start),
        .fill_value  (fill_value),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
`endif
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_q)
    );

    function automatic logic [7:0] pattern(int i);
        return 8'(i * 7 + 19);
    endfunction

    // Single-port RAM with a registered read that holds dataOut while writing.
    // The first clock edge preloads a known pattern.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= pattern(i);
            ram_loaded <= 1'b1;
        end else if (ram_wEn) begin
            ram_mem[ram_addr] <= ram_dataIn;
        end else begin
            ram_q <= ram_mem[ram_addr];
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_miss: got %b want 0", rd_miss); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ack: got %b want 0", wr_ack); end
        checks++; if (ram_wEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_wEn: got %b want 0", ram_wEn); end
        checks++; if (ram_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_ram_addr: got %h want 00", ram_addr); end
        checks++; if (ram_dataIn !== 8'h00) begin errors++; $display("[TB] FAIL reset_ram_dataIn: got %h want 00", ram_dataIn); end
`ifdef IMG_FILL_EN
        checks++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fill: got busy=%b done=%b want 0/0", fill_busy, fill_done); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_stream();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            rd_req  = (c < 16);
            rd_addr = 8'(c);
            #1;
            if (c == 0) begin
                checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_valid: got %b want 0", rd_valid); end
            end else begin
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b want 1", c, rd_valid); end
                checks++; if (rd_data !== model_mem[c-1]) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", c - 1, rd_data, model_mem[c-1]); end
            end
            checks++; if (rd_miss !== 1'b0) begin errors++; $display("[TB] FAIL stream_miss[%0d]: got %b want 0", c, rd_miss); end
        end
    endtask

    task automatic test_write_idle();
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'hAB;
        #1;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL idle_wr_ack: got %b want 1", wr_ack); end
        checks++; if (ram_wEn !== 1'b1 || ram_addr !== 8'h20 || ram_dataIn !== 8'hAB)
            begin errors++; $display("[TB] FAIL idle_ram_port: got wEn=%b addr=%h din=%h want 1/20/ab", ram_wEn, ram_addr, ram_dataIn); end
        model_mem[8'h20] = 8'hAB;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h20;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_pulse: got %b want 0", wr_ack); end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hAB) begin errors++; $display("[TB] FAIL idle_readback: got valid=%b data=%h want 1/ab", rd_valid, rd_data); end
        checks++; if (ram_wEn !== 1'b0 || ram_addr !== 8'h00 || ram_dataIn !== 8'h00)
            begin errors++; $display("[TB] FAIL none_ram_port: got wEn=%b addr=%h din=%h want 0/00/00", ram_wEn, ram_addr, ram_dataIn); end
    endtask

    task automatic test_starvation();
        int ack_cycle;
        ack_cycle = 0;
        for (int c = 1; c <= 40 && ack_cycle == 0; c++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 8'(8'h40 + c);
            wr_req = 1'b1; wr_addr = 8'h05; wr_data = 8'h3C;
            #1;
            if (wr_ack === 1'b1) ack_cycle = c;
        end
        checks++; if (ack_cycle != LIMIT + 1) begin errors++; $display("[TB] FAIL starve_ack_cycle: got %0d want %0d", ack_cycle, LIMIT + 1); end
        model_mem[8'h05] = 8'h3C;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h05;
        #1;
        checks++; if (rd_valid !== 1'b0 || rd_miss !== 1'b1) begin errors++; $display("[TB] FAIL starve_drop: got valid=%b miss=%b want 0/1", rd_valid, rd_miss); end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_miss !== 1'b0 || rd_data !== 8'h3C)
            begin errors++; $display("[TB] FAIL starve_resume: got valid=%b miss=%b data=%h want 1/0/3c", rd_valid, rd_miss, rd_data); end
    endtask

    task automatic test_abandon();
        int ack_cycle;
        int early_acks;
        early_acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 8'(8'h80 + c);
            wr_req = 1'b1; wr_addr = 8'h66; wr_data = 8'hEE;
            #1;
            if (wr_ack === 1'b1) early_acks++;
        end
        checks++; if (early_acks != 0) begin errors++; $display("[TB] FAIL abandon_no_ack: got %0d acks want 0", early_acks); end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h66;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 8'h90;
        wr_req = 1'b1;
        #1;
        checks++; if (rd_data !== model_mem[8'h66]) begin errors++; $display("[TB] FAIL abandon_no_write: got %h want %h", rd_data, model_mem[8'h66]); end
        ack_cycle = (wr_ack === 1'b1) ? 1 : 0;
        for (int c = 2; c <= 40 && ack_cycle == 0; c++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 8'(8'h90 + c);
            #1;
            if (wr_ack === 1'b1) ack_cycle = c;
        end
        checks++; if (ack_cycle != LIMIT + 1) begin errors++; $display("[TB] FAIL abandon_fresh_wait: got %0d want %0d", ack_cycle, LIMIT + 1); end
        model_mem[8'h66] = 8'hEE;
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_random();
        bit         pend;
        logic [7:0] pa, pd;
        int         waited;
        bit         prev_rd, prev_read, exp_ack, exp_read;
        logic [7:0] prev_data;
        pend = 0; waited = 0; pa = 0; pd = 0;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        prev_rd = 0; prev_read = 0; prev_data = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1; waited = 0; pa = 8'($urandom); pd = 8'($urandom);
            end
            rd_req  = ($urandom_range(0, 99) < ((c < 200) ? 80 : 97));
            rd_addr = 8'($urandom);
            wr_req  = pend; wr_addr = pa; wr_data = pd;
            #1;
            checks++; if (rd_valid !== prev_read || rd_miss !== (prev_rd && !prev_read))
                begin errors++; $display("[TB] FAIL rand_status[%0d]: got valid=%b miss=%b want %b/%b", c, rd_valid, rd_miss, prev_read, prev_rd && !prev_read); end
            if (prev_read) begin
                checks++; if (rd_data !== prev_data) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h want %h", c, rd_data, prev_data); end
            end
            // The write wins when the RAM is idle or its wait has reached the limit.
            exp_ack  = pend && (waited == LIMIT || !rd_req);
            exp_read = rd_req && !exp_ack;
            checks++; if (wr_ack !== exp_ack || ram_wEn !== exp_ack)
                begin errors++; $display("[TB] FAIL rand_ack[%0d]: got ack=%b wEn=%b want %b", c, wr_ack, ram_wEn, exp_ack); end
            if (exp_read) begin
                checks++; if (ram_addr !== rd_addr) begin errors++; $display("[TB] FAIL rand_raddr[%0d]: got %h want %h", c, ram_addr, rd_addr); end
            end
            prev_rd = rd_req; prev_read = exp_read; prev_data = model_mem[rd_addr];
            if (exp_ack) begin
                model_mem[pa] = pd; pend = 0;
            end else if (pend) begin
                waited++;
            end
        end
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
    endtask

`ifdef IMG_FILL_EN
    task automatic test_fill();
        int  busy_cycles, done_cnt, ack_cycle;
        bit  ack_ok;
        busy_cycles = 0; done_cnt = 0; ack_cycle = -1; ack_ok = 0;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0; fill_value = 8'h00; fill_start = 1'b1;
        #1;
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("[TB] FAIL fill_start_idle: got busy=%b want 0", fill_busy); end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            fill_start = 1'b0;
            if (c == 0) begin wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h99; end
            if (ack_cycle >= 0) wr_req = 1'b0;
            #1;
            if (fill_busy === 1'b1) busy_cycles++;
            if (fill_done === 1'b1) done_cnt++;
            if (wr_ack === 1'b1 && ack_cycle < 0) begin
                ack_cycle = c;
                ack_ok = (fill_busy === 1'b0) && (fill_done === 1'b1);
            end
        end
        checks++; if (busy_cycles != 256) begin errors++; $display("[TB] FAIL fill_busy_len: got %0d want 256", busy_cycles); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL fill_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (ack_cycle != 256 || !ack_ok) begin errors++; $display("[TB] FAIL fill_wr_after: got ack cycle %0d (in done=%b) want 256", ack_cycle, ack_ok); end
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        if (ack_cycle >= 0) model_mem[8'h30] = 8'h99;
        for (int a = 0; a <= 256; a++) begin
            @(negedge clk);
            rd_req = (a < 256); rd_addr = 8'(a);
            #1;
            if (a > 0) begin
                checks++; if (rd_data !== model_mem[a-1]) begin errors++; $display("[TB] FAIL fill_readback[%0d]: got %h want %h", a - 1, rd_data, model_mem[a-1]); end
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_fill_reset();
        bit found;
        int done_cnt;
        found = 0; done_cnt = 0;
        @(negedge clk);
        fill_value = 8'h77; fill_start = 1'b1;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            fill_start = 1'b0;
            #1;
            if (fill_busy === 1'b1 && ram_wEn === 1'b1 && ram_addr === 8'd100) begin
                found = 1;
                reset = 1'b1;
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL fillrst_reach_100: got no write at word 100 want one"); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (fill_busy !== 1'b0) begin errors++; $display("[TB] FAIL fillrst_busy: got %b want 0", fill_busy); end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (fill_done === 1'b1 || fill_busy === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL fillrst_no_done: got %0d busy/done cycles want 0", done_cnt); end
        for (int i = 0; i <= 100; i++) model_mem[i] = 8'h77;
        for (int a = 0; a <= 256; a++) begin
            @(negedge clk);
            rd_req = (a < 256); rd_addr = 8'(a);
            #1;
            if (a > 0) begin
                checks++; if (rd_data !== model_mem[a-1]) begin errors++; $display("[TB] FAIL fillrst_readback[%0d]: got %h want %h", a - 1, rd_data, model_mem[a-1]); end
            end
        end
        rd_req = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = pattern(i);
        reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef IMG_FILL_EN
        fill_start = 1'b0; fill_value = '0;
`endif
        test_reset();
        test_read_stream();
        test_write_idle();
        test_starvation();
        test_abandon();
        test_random();
`ifdef IMG_FILL_EN
        test_fill();
        test_fill_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
